// File: rtl/digit_scan_mux_pkg.sv
// Shared constants and helpers for the multiplexed digit scanner.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package digit_scan_mux_pkg;

  localparam int NIBBLE_W           = 4;
  localparam int DEFAULT_NUM_DIGITS = 4;

  // Wide enough for the largest supported display (8 digits); users slice it.
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // Width of a slot index for n digits; never narrower than one bit.
  function automatic int slot_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_scan_mux_if.sv
// Display-side bundle: digit data/controls in, decoder nibble and anodes out.
// Latency: n/a (wires only).
// Backpressure: none; load is a fire-and-forget strobe.
// Ports: digits_in/digit_en/blink_en/load (to scanner), nibble_out/anode_n/frame_tick (from scanner).
interface digit_scan_mux_if
  import digit_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
);

  logic [NIBBLE_W*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]          digit_en;
  logic [NUM_DIGITS-1:0]          blink_en;
  logic                           load;
  logic [NIBBLE_W-1:0]            nibble_out;
  logic [NUM_DIGITS-1:0]          anode_n;
  logic                           frame_tick;

  modport master (
    output digits_in, digit_en, blink_en, load,
    input  nibble_out, anode_n, frame_tick
  );

  modport slave (
    input  digits_in, digit_en, blink_en, load,
    output nibble_out, anode_n, frame_tick
  );

endinterface

// File: rtl/digit_scan_mux_scan_prescaler.sv
// Modulo-REFRESH_DIV slot timer with terminal-count pulse and dead-time flag.
// Latency: tc is combinational from the count; lit_next describes the next count.
// Backpressure: none; free-running.
// Ports: clk, rst (sync, active-high), tc (count == REFRESH_DIV-1), lit_next (next count >= DEAD_CYCLES).
module digit_scan_mux_scan_prescaler #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tc,
  output logic lit_next
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  // The parent registers its outputs from next-state values, so the
  // dead-time test is made against the count that will be current next cycle.
  always_comb begin
    tc       = (cnt == CW'(REFRESH_DIV - 1));
    cnt_nx   = tc ? '0 : cnt + CW'(1);
    lit_next = (int'(cnt_nx) >= DEAD_CYCLES);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nx;
    end
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed 7-segment digit scanner with frame-synchronous update, blanking, blink and dead time.
// Latency: outputs registered and aligned with the scan counters; load shows from the next frame start.
// Backpressure: none; loads before a frame boundary overwrite each other (last wins).
// Ports: clk, rst (sync, active-high), bus (slave: digits_in/digit_en/blink_en/load in; nibble_out/anode_n/frame_tick out).
module digit_scan_mux
  import digit_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV  = 50000,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic           clk,
  input  logic           rst,
  digit_scan_mux_if.slave bus
);

  localparam int SW = slot_w(NUM_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int VW = NIBBLE_W * NUM_DIGITS;
  localparam logic [SW-1:0]         LAST_SLOT  = SW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0]         LAST_FRAME = FW'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] DARK       = ANODE_OFF[NUM_DIGITS-1:0];

  logic slot_adv;
  logic lit_next;

  logic [SW-1:0]         slot;
  logic [FW-1:0]         frame_cnt;
  logic                  blink_phase;
  logic                  pending;
  logic [VW-1:0]         stg_val;
  logic [NUM_DIGITS-1:0] stg_en;
  logic [NUM_DIGITS-1:0] stg_blink;
  logic [VW-1:0]         act_val;
  logic [NUM_DIGITS-1:0] act_en;
  logic [NUM_DIGITS-1:0] act_blink;

  logic                  boundary;
  logic [SW-1:0]         slot_nx;
  logic                  blink_phase_nx;
  logic [VW-1:0]         act_val_nx;
  logic [NUM_DIGITS-1:0] act_en_nx;
  logic [NUM_DIGITS-1:0] act_blink_nx;
  logic                  vis_nx;

  digit_scan_mux_scan_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .tc       (slot_adv),
    .lit_next (lit_next)
  );

  // Everything the registered outputs need is computed for the next cycle,
  // so nibble_out/anode_n line up exactly with the slot and prescaler state.
  always_comb begin
    boundary       = slot_adv && (slot == LAST_SLOT);
    slot_nx        = slot;
    blink_phase_nx = blink_phase;
    act_val_nx     = act_val;
    act_en_nx      = act_en;
    act_blink_nx   = act_blink;

    if (slot_adv) begin
      slot_nx = boundary ? '0 : slot + SW'(1);
    end

    if (boundary) begin
      if (frame_cnt == LAST_FRAME) begin
        blink_phase_nx = ~blink_phase;
      end
      // A load landing on the boundary itself bypasses staging.
      if (bus.load) begin
        act_val_nx   = bus.digits_in;
        act_en_nx    = bus.digit_en;
        act_blink_nx = bus.blink_en;
      end else if (pending) begin
        act_val_nx   = stg_val;
        act_en_nx    = stg_en;
        act_blink_nx = stg_blink;
      end
    end

    vis_nx = act_en_nx[slot_nx] && !(act_blink_nx[slot_nx] && blink_phase_nx) && lit_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot           <= '0;
      frame_cnt      <= '0;
      blink_phase    <= 1'b0;
      pending        <= 1'b0;
      stg_val        <= '0;
      stg_en         <= '0;
      stg_blink      <= '0;
      act_val        <= '0;
      act_en         <= '0;
      act_blink      <= '0;
      bus.nibble_out <= '0;
      bus.anode_n    <= DARK;
      bus.frame_tick <= 1'b0;
    end else begin
      if (bus.load) begin
        stg_val   <= bus.digits_in;
        stg_en    <= bus.digit_en;
        stg_blink <= bus.blink_en;
      end

      if (boundary) begin
        pending   <= 1'b0;
        frame_cnt <= (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + FW'(1);
      end else if (bus.load) begin
        pending <= 1'b1;
      end

      slot        <= slot_nx;
      blink_phase <= blink_phase_nx;
      act_val     <= act_val_nx;
      act_en      <= act_en_nx;
      act_blink   <= act_blink_nx;

      // Decoder input follows the slot even through dead time.
      bus.nibble_out <= act_val_nx[slot_nx*NIBBLE_W +: NIBBLE_W];
      bus.anode_n    <= vis_nx ? ~(NUM_DIGITS'(1) << slot_nx) : DARK;
      bus.frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Self-checking bench for digit_scan_mux: directed scenarios plus random loads/resets.
// Latency: n/a.
// Backpressure: n/a.
module tb_digit_scan_mux;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int D  = 1;
  localparam int BF = 2;
  localparam int NR = N * R;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  digit_scan_mux_if #(.NUM_DIGITS(N)) bus ();

  digit_scan_mux #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .DEAD_CYCLES  (D),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          c;
    logic [15:0] v;
    logic [3:0]  en;
    logic [3:0]  bl;
  } load_t;

  load_t loads[$];
  int    t;
  bit    started;
  int    checks;
  int    failures;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, t, got, exp);
    end
  endtask

  // Cycle t counts from reset release. Frame f = t/NR; the frame shows the
  // most recent load sampled strictly before its first cycle.
  function automatic void model(input int tt, output logic [3:0] nib,
                                output logic [3:0] an, output logic ft);
    int    f, s, p, bp;
    load_t a;
    a.c = -1; a.v = '0; a.en = '0; a.bl = '0;
    f  = tt / NR;
    s  = (tt / R) % N;
    p  = tt % R;
    bp = (f / BF) % 2;
    foreach (loads[i]) if (loads[i].c < f * NR) a = loads[i];
    nib = a.v[s*4 +: 4];
    an  = 4'hF;
    if (a.en[s] && !(a.bl[s] && bp == 1) && p >= D) an[s] = 1'b0;
    ft = (tt > 0) && (tt % NR == 0);
  endfunction

  always @(negedge clk) begin
    logic [3:0] en_nib, en_an;
    logic       en_ft;
    if (started) begin
      model(t, en_nib, en_an, en_ft);
      chk("nibble_out", 16'(bus.nibble_out), 16'(en_nib));
      chk("anode_n", 16'(bus.anode_n), 16'(en_an));
      chk("frame_tick", 16'(bus.frame_tick), 16'(en_ft));
    end
  end

  task automatic step();
    @(posedge clk);
    if (rst) begin
      t = 0;
      loads.delete();
      started = 1'b1;
    end else begin
      if (bus.load) begin
        load_t l;
        l.c  = t;
        l.v  = bus.digits_in;
        l.en = bus.digit_en;
        l.bl = bus.blink_en;
        loads.push_back(l);
      end
      t++;
    end
    #1;
  endtask

  task automatic goto_pos(input int pos);
    do step(); while (t % NR != pos);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] bl);
    bus.digits_in = v;
    bus.digit_en  = en;
    bus.blink_en  = bl;
    bus.load      = 1'b1;
    step();
    bus.load      = 1'b0;
  endtask

  initial begin
    int lit;
    checks = 0; failures = 0; t = 0; started = 1'b0;
    rst = 1'b1;
    bus.load = 1'b0; bus.digits_in = '0; bus.digit_en = '0; bus.blink_en = '0;
    repeat (3) step();
    chk("reset_anode", 16'(bus.anode_n), 16'h000F);
    chk("reset_nibble", 16'(bus.nibble_out), 16'h0000);
    chk("reset_tick", 16'(bus.frame_tick), 16'h0000);
    rst = 1'b0;

    // Dark display, ticks every frame.
    for (int i = 0; i < 64; i++) begin
      step();
      if (t % NR == 0) chk("tick_lit", 16'(bus.frame_tick), 16'h0001);
      if (t == 33) chk("dark_lit", 16'(bus.anode_n), 16'h000F);
    end

    // All digits visible.
    goto_pos(5);
    do_load(16'h1234, 4'hF, 4'h0);
    goto_pos(0);
    chk("s0_dead_anode", 16'(bus.anode_n), 16'h000F);
    chk("s0_dead_nibble", 16'(bus.nibble_out), 16'h0004);
    goto_pos(1);
    chk("s0_nibble", 16'(bus.nibble_out), 16'h0004);
    chk("s0_anode", 16'(bus.anode_n), 16'h000E);
    goto_pos(5);
    chk("s1_nibble", 16'(bus.nibble_out), 16'h0003);
    chk("s1_anode", 16'(bus.anode_n), 16'h000D);
    goto_pos(9);
    chk("s2_anode", 16'(bus.anode_n), 16'h000B);
    goto_pos(13);
    chk("s3_nibble", 16'(bus.nibble_out), 16'h0001);
    chk("s3_anode", 16'(bus.anode_n), 16'h0007);

    // Digit 2 blanked.
    do_load(16'h1234, 4'b1011, 4'h0);
    goto_pos(0);
    goto_pos(9);
    chk("blank_nibble", 16'(bus.nibble_out), 16'h0002);
    chk("blank_anode", 16'(bus.anode_n), 16'h000F);

    // Digit 0 blinks with a 2-frame half-period.
    goto_pos(5);
    do_load(16'h1234, 4'hF, 4'b0001);
    goto_pos(0);
    lit = 0;
    for (int i = 0; i < 4; i++) begin
      goto_pos(1);
      if (bus.anode_n == 4'b1110) lit++;
    end
    chk("blink_lit_frames", 16'(lit), 16'h0002);
    repeat (2 * NR) step();

    // Two loads within one frame: only the second one is ever shown.
    goto_pos(3);
    do_load(16'hAAAA, 4'hF, 4'h0);
    goto_pos(10);
    do_load(16'h5555, 4'hF, 4'h0);
    goto_pos(0);
    for (int i = 0; i < NR; i++) begin
      if (t % R == 1) chk("last_load_wins", 16'(bus.nibble_out), 16'h0005);
      step();
    end

    // Load on the boundary cycle goes straight to the new frame.
    goto_pos(15);
    do_load(16'h9876, 4'hF, 4'h0);
    goto_pos(1);
    chk("bypass_s0", 16'(bus.nibble_out), 16'h0006);
    chk("bypass_s0_anode", 16'(bus.anode_n), 16'h000E);
    goto_pos(9);
    chk("bypass_s2", 16'(bus.nibble_out), 16'h0008);
    do_load(16'h1111, 4'hF, 4'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_anode", 16'(bus.anode_n), 16'h000F);
    chk("rst_mid_nibble", 16'(bus.nibble_out), 16'h0000);
    repeat (2 * NR) step();
    goto_pos(1);
    chk("pending_cleared", 16'(bus.anode_n), 16'h000F);

    // Random loads and occasional resets against the model.
    for (int i = 0; i < 2500; i++) begin
      bus.load      = ($urandom_range(0, 19) == 0);
      bus.digits_in = 16'($urandom);
      bus.digit_en  = 4'($urandom);
      bus.blink_en  = 4'($urandom);
      rst           = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    bus.load = 1'b0;
    repeat (2 * NR) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
